// File: rtl/hex_file_loader_pkg.sv
// rtl/hex_file_loader_pkg.sv - shared byte constants and FSM state encoding
// Holds the framing bytes used by the UART file receiver and the loader
// state codes exposed on the debug state port.
package hex_file_loader_pkg;

    // Framing bytes, identical to the receiver's values
    localparam logic [7:0] CHAR_SOT = 8'h02;
    localparam logic [7:0] CHAR_EOF = 8'h04;
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;

    // Loader FSM states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_SOT = 3'd1;
    localparam logic [2:0] ST_COLLECT  = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/hex_file_loader_decode.sv
// rtl/hex_file_loader_decode.sv - ASCII hex character to nibble decoder
// Ports: ch (ASCII byte in), invalid (1 when ch is not 0-9/A-F/a-f),
//        nibble (decoded value, 0 when invalid).
module hex_char_decode (
    input  logic [7:0] ch,
    output logic       invalid,
    output logic [3:0] nibble
);

    always_comb begin
        invalid = 1'b0;
        nibble  = 4'h0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            nibble = ch[3:0];
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them to 10
            nibble = ch[3:0] + 4'd9;
        end else begin
            invalid = 1'b1;
        end
    end

endmodule

// File: rtl/hex_file_loader.sv
// rtl/hex_file_loader.sv - parses one hex word per line from the receiver FIFO into memory
// Ports: clk/reset; cfg_valid/cfg_sel/cfg_base start a load;
//        rx_byte/rx_byte_rdy/rx_byte_re pop the receiver FIFO;
//        mem_we/mem_ready/mem_sel/mem_addr/mem_wdata write the target memory;
//        load_busy/load_done/load_error/word_count/state report status.
module hex_file_loader
    import hex_file_loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [7:0]        cfg_sel,
    input  logic [7:0]        cfg_base,
    input  logic [7:0]        rx_byte,
    input  logic              rx_byte_rdy,
    output logic              rx_byte_re,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [7:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count,
    output logic [2:0]        state
);

    localparam int DIGITS = DATA_W / 4;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W + 1)'(1);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] asm_q;
    logic              pend_eof;
    logic              wrapped;   // a write has already landed at the top address
    logic              hex_invalid;
    logic [3:0]        hex_nibble;
    logic              is_term;
    logic              overflow;

    hex_char_decode u_decode (
        .ch      (rx_byte),
        .invalid (hex_invalid),
        .nibble  (hex_nibble)
    );

    assign is_term    = (rx_byte == CHAR_CR) || (rx_byte == CHAR_LF);
    assign overflow   = wrapped || word_count[ADDR_W];
    assign rx_byte_re = rx_byte_rdy && (state == ST_WAIT_SOT || state == ST_COLLECT);
    // An overflowing word passes through WRITE without a write strobe
    assign mem_we     = (state == ST_WRITE) && !overflow;
    assign load_busy  = (state != ST_IDLE);
    assign load_done  = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            mem_sel    <= 8'h00;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            load_error <= 1'b0;
            word_count <= '0;
            cnt        <= '0;
            asm_q      <= '0;
            pend_eof   <= 1'b0;
            wrapped    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        mem_sel    <= cfg_sel;
                        mem_addr   <= ADDR_W'(cfg_base);
                        word_count <= '0;
                        load_error <= 1'b0;
                        wrapped    <= 1'b0;
                        pend_eof   <= 1'b0;
                        state      <= ST_WAIT_SOT;
                    end
                end

                ST_WAIT_SOT: begin
                    if (rx_byte_rdy && rx_byte == CHAR_SOT) begin
                        cnt   <= '0;
                        state <= ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (rx_byte_rdy) begin
                        if (!hex_invalid) begin
                            if (cnt < CNT_FULL) begin
                                asm_q <= {asm_q[DATA_W-5:0], hex_nibble};
                                cnt   <= cnt + CNT_ONE;
                            end else begin
                                load_error <= 1'b1;
                            end
                        end else if (is_term) begin
                            if (cnt == CNT_FULL) begin
                                mem_wdata <= asm_q;
                                state     <= ST_WRITE;
                            end else if (cnt != '0) begin
                                load_error <= 1'b1;
                            end
                            cnt <= '0;
                        end else if (rx_byte == CHAR_EOF) begin
                            if (cnt == CNT_FULL) begin
                                // Last line had no terminator: write it, then finish
                                mem_wdata <= asm_q;
                                pend_eof  <= 1'b1;
                                state     <= ST_WRITE;
                            end else begin
                                if (cnt != '0) begin
                                    load_error <= 1'b1;
                                end
                                state <= ST_DONE;
                            end
                            cnt <= '0;
                        end
                    end
                end

                ST_WRITE: begin
                    if (overflow) begin
                        load_error <= 1'b1;
                        pend_eof   <= 1'b0;
                        state      <= pend_eof ? ST_DONE : ST_COLLECT;
                    end else if (mem_ready) begin
                        if (&mem_addr) begin
                            wrapped <= 1'b1;
                        end
                        mem_addr   <= mem_addr + ADDR_ONE;
                        word_count <= word_count + WC_ONE;
                        pend_eof   <= 1'b0;
                        state      <= pend_eof ? ST_DONE : ST_COLLECT;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_file_loader.sv
// tb/tb_hex_file_loader.sv - self-checking bench for hex_file_loader
module tb_hex_file_loader;

    typedef struct {
        logic [7:0]  sel;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_sel = 8'h00;
    logic [7:0]  cfg_base = 8'h00;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_byte_rdy = 1'b0;
    logic        rx_byte_re;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic [7:0]  mem_sel;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [8:0]  word_count;
    logic [2:0]  state;

    int   errors = 0;
    int   checks = 0;
    int   pop_count = 0;
    int   done_count = 0;
    bit   will_pop = 0;
    logic [7:0] fifo[$];
    wr_t  exp_q[$];

    hex_file_loader dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_base(cfg_base),
        .rx_byte(rx_byte), .rx_byte_rdy(rx_byte_rdy), .rx_byte_re(rx_byte_re),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .load_busy(load_busy), .load_done(load_done), .load_error(load_error),
        .word_count(word_count), .state(state)
    );

    always #5 clk = ~clk;

    // Receiver FIFO model: pop decision taken mid-cycle, applied just after the edge
    always @(negedge clk) will_pop = rx_byte_re;

    always @(posedge clk) begin
        #1;
        if (will_pop && fifo.size() > 0) begin
            void'(fifo.pop_front());
            pop_count++;
        end
        rx_byte_rdy = (fifo.size() > 0);
        rx_byte     = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    // Memory-side scoreboard
    always @(negedge clk) begin
        if (load_done) done_count++;
        if (mem_we && mem_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data || mem_sel !== e.sel) begin
                    errors++;
                    $display("FAIL write: got sel=%h addr=%h data=%h, required sel=%h addr=%h data=%h",
                             mem_sel, mem_addr, mem_wdata, e.sel, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        rx_byte_rdy = 1'b1;
        rx_byte     = fifo[0];
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push_byte(s[i]);
    endtask

    task automatic expect_write(input logic [7:0] sel, input logic [7:0] addr, input logic [31:0] data);
        wr_t w;
        w.sel = sel; w.addr = addr; w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic send_cfg(input logic [7:0] sel, input logic [7:0] base);
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_sel = sel; cfg_base = base;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (load_done) seen = 1;
        end
        @(negedge clk);
    endtask

    task automatic wait_we(output bit seen);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (mem_we) seen = 1;
        end
    endtask

    task automatic test_reset;
        checks++;
        if (state !== 3'd0 || mem_we !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got state=%0d we=%b busy=%b done=%b, required 0 0 0 0",
                     state, mem_we, load_busy, load_done);
        end
        checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 32'h0 || word_count !== 9'h0 ||
            load_error !== 1'b0 || mem_sel !== 8'h00 || rx_byte_re !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h data=%h wc=%0d err=%b sel=%h re=%b, required all zero",
                     mem_addr, mem_wdata, word_count, load_error, mem_sel, rx_byte_re);
        end
    endtask

    task automatic test_basic;
        bit seen;
        int d0;
        d0 = done_count;
        push_byte(8'h02); push_str("DEADBEEF"); push_byte(8'h0D); push_byte(8'h0A);
        push_str("0000000a"); push_byte(8'h0A); push_byte(8'h04);
        expect_write(8'h01, 8'h10, 32'hDEADBEEF);
        expect_write(8'h01, 8'h11, 32'h0000000A);
        @(negedge clk);
        checks++;
        if (rx_byte_re !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_pop: got re=%b, required 0", rx_byte_re);
        end
        send_cfg(8'h01, 8'h10);
        wait_done(seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL basic_done_timeout: got no load_done, required one"); end
        checks++;
        if (done_count - d0 !== 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d, required 1", done_count - d0);
        end
        checks++;
        if (word_count !== 9'd2 || load_error !== 1'b0 || load_busy !== 1'b0 || mem_addr !== 8'h12) begin
            errors++;
            $display("FAIL basic_status: got wc=%0d err=%b busy=%b addr=%h, required 2 0 0 12",
                     word_count, load_error, load_busy, mem_addr);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_missing: got %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall;
        bit seen;
        int p0;
        mem_ready = 1'b0;
        push_byte(8'h02); push_str("11223344"); push_byte(8'h0A); push_byte(8'h04);
        expect_write(8'h02, 8'h30, 32'h11223344);
        send_cfg(8'h02, 8'h30);
        wait_we(seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL stall_we_timeout: got no mem_we, required mem_we"); end
        p0 = pop_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 8'h30 || mem_wdata !== 32'h11223344 ||
                pop_count != p0 || mem_sel !== 8'h02) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got we=%b addr=%h data=%h sel=%h pops=%0d, required 1 30 11223344 02 %0d",
                         i, mem_we, mem_addr, mem_wdata, mem_sel, pop_count, p0);
            end
            // A stray cfg pulse mid-load must be ignored
            if (i == 1) begin cfg_valid = 1'b1; cfg_sel = 8'h09; cfg_base = 8'h77; end
            if (i == 2) cfg_valid = 1'b0;
        end
        mem_ready = 1'b1;
        wait_done(seen);
        checks++;
        if (!seen || word_count !== 9'd1 || load_error !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_end: got done=%b wc=%0d err=%b pending=%0d, required 1 1 0 0",
                     seen, word_count, load_error, exp_q.size());
        end
    endtask

    task automatic test_partial;
        bit seen;
        push_byte(8'h02); push_str("1234"); push_byte(8'h0A);
        push_str("55667788"); push_byte(8'h0A); push_byte(8'h04);
        expect_write(8'h01, 8'h20, 32'h55667788);
        send_cfg(8'h01, 8'h20);
        wait_done(seen);
        checks++;
        if (!seen || load_error !== 1'b1 || word_count !== 9'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL partial: got done=%b err=%b wc=%0d pending=%0d, required 1 1 1 0",
                     seen, load_error, word_count, exp_q.size());
        end
    endtask

    task automatic test_overflow;
        bit seen;
        push_byte(8'h02); push_str("AAAAAAAA"); push_byte(8'h0A);
        push_str("BBBBBBBB"); push_byte(8'h0A); push_byte(8'h04);
        expect_write(8'h00, 8'hFF, 32'hAAAAAAAA);
        send_cfg(8'h00, 8'hFF);
        wait_done(seen);
        checks++;
        if (!seen || load_error !== 1'b1 || word_count !== 9'd1 || mem_addr !== 8'h00 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL overflow: got done=%b err=%b wc=%0d addr=%h pending=%0d, required 1 1 1 00 0",
                     seen, load_error, word_count, mem_addr, exp_q.size());
        end
    endtask

    task automatic test_eof_no_term;
        bit seen;
        push_byte(8'h02); push_str("CAFEF00D"); push_byte(8'h04);
        expect_write(8'h01, 8'h40, 32'hCAFEF00D);
        send_cfg(8'h01, 8'h40);
        wait_done(seen);
        checks++;
        if (!seen || load_error !== 1'b0 || word_count !== 9'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL eof_no_term: got done=%b err=%b wc=%0d pending=%0d, required 1 0 1 0",
                     seen, load_error, word_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        mem_ready = 1'b0;
        push_byte(8'h02); push_str("12345678"); push_byte(8'h0A);
        send_cfg(8'h03, 8'h50);
        wait_we(seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_we_timeout: got no mem_we, required mem_we"); end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 32'h0 || state !== 3'd0 ||
            load_busy !== 1'b0 || mem_sel !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_outputs: got we=%b addr=%h data=%h state=%0d busy=%b sel=%h, required all zero",
                     mem_we, mem_addr, mem_wdata, state, load_busy, mem_sel);
        end
        @(negedge clk);
        reset = 1'b0;
        fifo.delete();
        rx_byte_rdy = 1'b0;
        rx_byte = 8'h00;
        mem_ready = 1'b1;
        push_byte(8'h02); push_str("0badc0de"); push_byte(8'h0D); push_byte(8'h0A); push_byte(8'h04);
        expect_write(8'h04, 8'h60, 32'h0BADC0DE);
        send_cfg(8'h04, 8'h60);
        wait_done(seen);
        checks++;
        if (!seen || load_error !== 1'b0 || word_count !== 9'd1 || mem_addr !== 8'h61 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_fresh: got done=%b err=%b wc=%0d addr=%h pending=%0d, required 1 0 1 61 0",
                     seen, load_error, word_count, mem_addr, exp_q.size());
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_stall;
        test_partial;
        test_overflow;
        test_eof_no_term;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
